// File: rtl/data_ram_arbiter_if.sv
// Bundle of the CPU MEM-stage port, the debug/loader burst port and the
// single-port data RAM connection shared by the arbiter and its environment.
interface data_ram_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  // Handshakes: cpu_req is held by the CPU until a cycle with cpu_stall = 0,
  // which is the cycle its access completes; dbg_req is sampled only in IDLE
  // and a burst then runs one beat per cycle, signalled by dbg_beat, with
  // dbg_done marking the last beat. No ready/valid back-pressure on the RAM.
  logic          cpu_req;
  logic          cpu_we;
  logic [AW+1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [3:0]    dbg_len;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_beat;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_done;
  logic          dbg_busy;

  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    output dbg_beat, dbg_rdata, dbg_done, dbg_busy,
    output ram_a, ram_d, ram_we,
    input  ram_q
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    input  dbg_beat, dbg_rdata, dbg_done, dbg_busy,
    input  ram_a, ram_d, ram_we,
    output ram_q
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// Arbitrates a single-port data RAM between the CPU MEM stage and a
// non-preemptible debug burst port, with a starvation limit on the CPU's priority.
module data_ram_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = 7,
  parameter int DW           = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  data_ram_arbiter_if.slave                   bus,
  output logic                                fsmState,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]   starveCount
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE = 1'b0, DBG = 1'b1} state_t;

  state_t        state, stateNext;
  logic          grant;
  logic [AW-1:0] baseAddr;
  logic [3:0]    burstLen;
  logic          burstWe;
  logic [3:0]    beatCnt;
  logic [SW-1:0] starveCnt;
  logic [AW-1:0] cpuWord;
  logic          unusedAddrBits;

  assign cpuWord        = bus.cpu_addr[AW+1:2];
  assign unusedAddrBits = ^bus.cpu_addr[1:0];
  assign bus.cpu_rdata  = bus.ram_q;
  assign bus.dbg_rdata  = bus.ram_q;
  assign fsmState       = (state == DBG);
  assign starveCount    = starveCnt;

  always_comb begin
    stateNext     = state;
    grant         = 1'b0;
    bus.ram_a     = cpuWord;
    bus.ram_d     = bus.cpu_wdata;
    bus.ram_we    = bus.cpu_req & bus.cpu_we;
    bus.cpu_stall = 1'b0;
    bus.dbg_beat  = 1'b0;
    bus.dbg_done  = 1'b0;
    bus.dbg_busy  = 1'b0;
    case (state)
      IDLE: begin
        // The CPU access in the grant cycle still goes through.
        if (bus.dbg_req && (!bus.cpu_req || starveCnt == SW'(STARVE_LIMIT))) begin
          grant     = 1'b1;
          stateNext = DBG;
        end
      end
      DBG: begin
        bus.ram_a     = baseAddr + AW'(beatCnt);
        bus.ram_d     = bus.dbg_wdata;
        bus.ram_we    = burstWe;
        bus.cpu_stall = bus.cpu_req;
        bus.dbg_beat  = 1'b1;
        bus.dbg_busy  = 1'b1;
        if (beatCnt == burstLen) begin
          bus.dbg_done = 1'b1;
          stateNext    = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    // A reset cycle must never write the RAM or show burst activity.
    if (rst) begin
      stateNext     = IDLE;
      grant         = 1'b0;
      bus.ram_we    = 1'b0;
      bus.cpu_stall = 1'b0;
      bus.dbg_beat  = 1'b0;
      bus.dbg_done  = 1'b0;
      bus.dbg_busy  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beatCnt   <= '0;
      starveCnt <= '0;
      baseAddr  <= '0;
      burstLen  <= '0;
      burstWe   <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE) begin
        if (grant) begin
          baseAddr  <= bus.dbg_addr;
          burstLen  <= bus.dbg_len;
          burstWe   <= bus.dbg_we;
          beatCnt   <= '0;
          starveCnt <= '0;
        end else if (bus.dbg_req && bus.cpu_req) begin
          if (starveCnt != SW'(STARVE_LIMIT)) starveCnt <= starveCnt + 1'b1;
        end else begin
          starveCnt <= '0;
        end
      end else begin
        beatCnt <= beatCnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a burst/starvation/memory model.
module tb_data_ram_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int L  = 8;
  localparam int DEPTH = 1 << AW;

  logic       clk;
  logic       rst;
  logic       fsm_state;
  logic [3:0] starve_count;

  data_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  data_ram_arbiter #(.STARVE_LIMIT(L), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fsmState    (fsm_state),
    .starveCount (starve_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM behind the port: asynchronous read, write on the clock edge
  logic [DW-1:0] ram_mem [DEPTH];
  assign bus.ram_q = ram_mem[bus.ram_a];
  always @(posedge clk) if (bus.ram_we === 1'b1) ram_mem[bus.ram_a] <= bus.ram_d;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / behavioural model
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] beat_log[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          burst_we = 1'b0;
  int            starve   = 0;
  int            done_cnt = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(negedge clk) begin
    logic [AW-1:0] a;
    logic          w;
    if (rst) begin
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_stall", bus.cpu_stall, 0);
      chk("rst_beat", bus.dbg_beat, 0);
      chk("rst_done", bus.dbg_done, 0);
      chk("rst_busy", bus.dbg_busy, 0);
      exp_q.delete();
      starve = 0;
    end else begin
      chk("starve_cnt", starve_count, starve);
      chk("fsm_state", fsm_state, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        a = exp_q[0];
        chk("dbg_ram_a", bus.ram_a, a);
        chk("dbg_ram_we", bus.ram_we, burst_we);
        if (burst_we) chk("dbg_ram_d", bus.ram_d, bus.dbg_wdata);
        chk("dbg_stall", bus.cpu_stall, bus.cpu_req);
        chk("dbg_beat", bus.dbg_beat, 1);
        chk("dbg_busy", bus.dbg_busy, 1);
        chk("dbg_done", bus.dbg_done, exp_q.size() == 1);
        chk("dbg_rdata", bus.dbg_rdata, ref_mem[a]);
        chk("dbg_cpu_rdata", bus.cpu_rdata, ref_mem[a]);
        if (burst_we) ref_mem[a] = bus.dbg_wdata;
        beat_log.push_back(a);
        if (exp_q.size() == 1) done_cnt++;
        void'(exp_q.pop_front());
      end else begin
        a = bus.cpu_addr[AW+1:2];
        w = bus.cpu_req & bus.cpu_we;
        chk("cpu_ram_a", bus.ram_a, a);
        chk("cpu_ram_we", bus.ram_we, w);
        if (w) chk("cpu_ram_d", bus.ram_d, bus.cpu_wdata);
        chk("idle_stall", bus.cpu_stall, 0);
        chk("idle_beat", bus.dbg_beat, 0);
        chk("idle_busy", bus.dbg_busy, 0);
        chk("idle_done", bus.dbg_done, 0);
        chk("cpu_rdata", bus.cpu_rdata, ref_mem[a]);
        chk("idle_dbg_rdata", bus.dbg_rdata, ref_mem[a]);
        if (w) ref_mem[a] = bus.cpu_wdata;
        if (bus.dbg_req && (!bus.cpu_req || starve == L)) begin
          for (int i = 0; i <= int'(bus.dbg_len); i++)
            exp_q.push_back(AW'((int'(bus.dbg_addr) + i) % DEPTH));
          burst_we = bus.dbg_we;
          starve   = 0;
        end else if (bus.dbg_req && bus.cpu_req) begin
          starve = (starve < L) ? starve + 1 : L;
        end else begin
          starve = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_len   = '0;
    bus.dbg_wdata = '0;
  endtask

  task automatic set_burst(input logic we, input logic [AW-1:0] addr, input logic [3:0] len);
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = we;
    bus.dbg_addr = addr;
    bus.dbg_len  = len;
  endtask

  initial begin
    int         n;
    logic [7:0] pat;
    rst = 1'b1;
    quiet_inputs();
    step(3);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_state", fsm_state, 0);
    chk("post_rst_starve", starve_count, 0);
    chk("post_rst_busy", bus.dbg_busy, 0);
    @(posedge clk); #1;

    // CPU-only store
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 9'h010; bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge clk); #1;
    chk("cpu_only_a", bus.ram_a, 4);
    chk("cpu_only_we", bus.ram_we, 1);
    chk("cpu_only_d", bus.ram_d, 32'hDEADBEEF);
    chk("cpu_only_stall", bus.cpu_stall, 0);
    @(posedge clk); #1;
    quiet_inputs();
    step(2);

    // idle grant, 4-beat write at 5
    beat_log.delete(); done_cnt = 0;
    set_burst(1'b1, 7'd5, 4'd3);
    bus.dbg_wdata = 32'h1234_5678;
    step(1);
    bus.dbg_req = 1'b0;
    step(6);
    chk("grant_beats", beat_log.size(), 4);
    if (beat_log.size() == 4) begin
      chk("grant_a0", beat_log[0], 5);
      chk("grant_a1", beat_log[1], 6);
      chk("grant_a2", beat_log[2], 7);
      chk("grant_a3", beat_log[3], 8);
    end
    chk("grant_done_cnt", done_cnt, 1);
    chk("grant_back_idle", fsm_state, 0);

    // starvation: both requests held high
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h020;
    set_burst(1'b0, 7'd20, 4'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (bus.dbg_beat) break;
      n++;
    end
    chk("starve_idle_cycles", n, 9);
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    chk("starve_stall_dbg", bus.cpu_stall, 1);
    step(3);
    chk("starve_cpu_resumed", bus.cpu_stall, 0);
    quiet_inputs();
    step(1);

    // wrap-around read burst at 126
    beat_log.delete();
    set_burst(1'b0, 7'd126, 4'd3);
    step(1);
    bus.dbg_req = 1'b0;
    step(6);
    chk("wrap_beats", beat_log.size(), 4);
    if (beat_log.size() == 4) begin
      chk("wrap_a0", beat_log[0], 126);
      chk("wrap_a1", beat_log[1], 127);
      chk("wrap_a2", beat_log[2], 0);
      chk("wrap_a3", beat_log[3], 1);
    end

    // reset during the 2nd beat of a 16-beat write
    set_burst(1'b1, 7'd40, 4'd15);
    bus.dbg_wdata = 32'hCAFE_0001;
    step(1);
    bus.dbg_req = 1'b0;
    step(1);
    beat_log.delete(); done_cnt = 0;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_ram_we", bus.ram_we, 0);
    chk("midrst_busy", bus.dbg_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(20);
    chk("midrst_no_beats", beat_log.size(), 0);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_starve", starve_count, 0);

    // back-to-back single-beat bursts
    set_burst(1'b1, 7'd3, 4'd0);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      pat[i] = bus.dbg_beat;
    end
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    step(3);
    chk("b2b_pattern", pat, 8'b1010_1010);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      bus.cpu_req   = ($urandom_range(0, 3) != 0);
      bus.cpu_we    = $urandom_range(0, 1) == 1;
      bus.cpu_addr  = (AW+2)'($urandom_range(0, (1 << (AW + 2)) - 1));
      bus.cpu_wdata = $urandom;
      if ($urandom_range(0, 7) == 0) bus.dbg_req = ~bus.dbg_req;
      bus.dbg_we    = $urandom_range(0, 1) == 1;
      bus.dbg_addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.dbg_len   = 4'($urandom_range(0, 15));
      bus.dbg_wdata = $urandom;
      step(1);
    end
    rst = 1'b0;
    quiet_inputs();
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
